// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - hh:mm:ss counter advanced by a synchronized 1 Hz edge, with validated time loads
// Optional feature: define TOD_PAUSE_EN to add the pause input that discards detected seconds.
module time_of_day_counter #(
    parameter int TICK_SYNC_STAGES = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       clk_1Hz,
`ifdef TOD_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_err,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_tick,
    output logic       day_tick
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } ld_state_e;

    logic [TICK_SYNC_STAGES-1:0] sync_q;
    logic [TICK_SYNC_STAGES-1:0] fill_q;
    logic                        prev_q;
    logic                        tick_edge;
    logic                        count_en;

    // The reset zeros in the chain are not real samples; prev keeps its reset 1
    // until real samples arrive, so a level already high at release is no edge.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[TICK_SYNC_STAGES-2:0], clk_1Hz};
            fill_q <= {fill_q[TICK_SYNC_STAGES-2:0], 1'b1};
            if (fill_q[TICK_SYNC_STAGES-1]) begin
                prev_q <= sync_q[TICK_SYNC_STAGES-1];
            end
        end
    end

    assign tick_edge = sync_q[TICK_SYNC_STAGES-1] & ~prev_q;

`ifdef TOD_PAUSE_EN
    assign count_en = tick_edge & ~pause;
`else
    assign count_en = tick_edge;
`endif

    ld_state_e  state_q, state_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       sec_tick_q, sec_tick_d;
    logic       day_tick_q, day_tick_d;
    logic       set_err_q, set_err_d;
    logic       load_legal;
    logic       load_ok;
    logic       load_bad;

    assign load_legal = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);

    always_comb begin
        state_d   = state_q;
        set_ready = 1'b0;
        load_ok   = 1'b0;
        load_bad  = 1'b0;
        if (state_q == ST_COMMIT) begin
            state_d = ST_IDLE;
        end else begin
            set_ready = 1'b1;
            if (set_valid) begin
                state_d  = ST_COMMIT;
                load_ok  = load_legal;
                load_bad = ~load_legal;
            end
        end
    end

    // An accepted legal load overrides a coincident second; it is not queued.
    always_comb begin
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        set_err_d  = load_bad;
        if (load_ok) begin
            hour_d = set_hour;
            min_d  = set_min;
            sec_d  = set_sec;
        end else if (count_en) begin
            sec_tick_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    if (hour_q == 5'd23) begin
                        hour_d     = 5'd0;
                        day_tick_d = 1'b1;
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_COMMIT;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            set_err_q  <= set_err_d;
        end
    end

    assign hour     = hour_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;
    assign set_err  = set_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb/tb_time_of_day_counter.sv - randomized and directed checks of time_of_day_counter against a seconds-of-day model
module tb_time_of_day_counter;

    logic       clk_100MHz = 1'b0;
    logic       reset_n;
    logic       clk_1Hz;
    logic       pause;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_tick;
    logic       day_tick;

    always #5 clk_100MHz = ~clk_100MHz;

    time_of_day_counter dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .clk_1Hz    (clk_1Hz),
`ifdef TOD_PAUSE_EN
        .pause      (pause),
`endif
        .set_valid  (set_valid),
        .set_ready  (set_ready),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .set_err    (set_err),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .sec_tick   (sec_tick),
        .day_tick   (day_tick)
    );

    // Reference: time kept as seconds-of-day; a second is a 0-then-1 pair of
    // 1 Hz samples seen two clocks later; the wave counts as high before reset.
    int exp_tod;
    bit exp_ready, exp_stick, exp_dtick, exp_err;
    bit hist[$];

    always @(posedge clk_100MHz or negedge reset_n) begin
        bit acc, legal, rise;
        if (!reset_n) begin
            exp_tod   = 0;
            exp_ready = 0;
            exp_stick = 0;
            exp_dtick = 0;
            exp_err   = 0;
            hist      = '{1'b1, 1'b1, 1'b1};
        end else begin
            hist.push_back(clk_1Hz);
            rise = hist[1] && !hist[0];
            void'(hist.pop_front());
            acc       = set_valid && exp_ready;
            legal     = (set_hour < 24) && (set_min < 60) && (set_sec < 60);
            exp_err   = acc && !legal;
            exp_stick = 0;
            exp_dtick = 0;
            if (acc && legal) begin
                exp_tod = set_hour * 3600 + set_min * 60 + set_sec;
            end else if (rise && !pause) begin
                exp_tod   = (exp_tod + 1) % 86400;
                exp_stick = 1;
                exp_dtick = (exp_tod == 0);
            end
            exp_ready = !acc;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int tick_cnt = 0;
    int day_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk_100MHz);
        check("hour", 32'(hour), 32'(exp_tod / 3600));
        check("min", 32'(min), 32'((exp_tod / 60) % 60));
        check("sec", 32'(sec), 32'(exp_tod % 60));
        check("sec_tick", 32'(sec_tick), 32'(exp_stick));
        check("day_tick", 32'(day_tick), 32'(exp_dtick));
        check("set_err", 32'(set_err), 32'(exp_err));
        check("set_ready", 32'(set_ready), 32'(exp_ready));
        if (sec_tick === 1'b1) tick_cnt++;
        if (day_tick === 1'b1) day_cnt++;
        if (set_err === 1'b1) err_cnt++;
    endtask

    task automatic load(input int h, input int m, input int s);
        bit got;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        set_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            got = set_ready;
            step();
        end
        set_valid = 1'b0;
        if (!got) check("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse(input int hi, input int lo);
        clk_1Hz = 1'b1;
        repeat (hi) step();
        clk_1Hz = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        int t0, d0, e0, s0;
        bit acc;
        reset_n   = 1'b0;
        clk_1Hz   = 1'b1;
        pause     = 1'b0;
        set_valid = 1'b0;
        set_hour  = '0;
        set_min   = '0;
        set_sec   = '0;

        repeat (3) step();
        check("rst_ready", 32'(set_ready), 32'd0);
        check("rst_time", {21'd0, hour, min, sec}, 32'd0);

        // Release with the 1 Hz wave already high: no second may be counted.
        reset_n = 1'b1;
        t0 = tick_cnt;
        step();
        check("ready_after_release", 32'(set_ready), 32'd1);
        repeat (6) step();
        clk_1Hz = 1'b0;
        repeat (4) step();
        check("no_tick_at_release", 32'(tick_cnt - t0), 32'd0);

        // Latency: second advances on the third edge counting the sampling edge.
        load(1, 2, 3);
        repeat (2) step();
        clk_1Hz = 1'b1;
        step();
        check("lat_e0", 32'(sec), 32'd3);
        step();
        check("lat_e1", 32'(sec), 32'd3);
        step();
        check("lat_e2", 32'(sec), 32'd4);
        check("lat_tick", 32'(sec_tick), 32'd1);
        repeat (2) step();
        clk_1Hz = 1'b0;
        repeat (4) step();

        t0 = tick_cnt;
        repeat (10) pulse(4, 4);
        repeat (4) step();
        check("ten_ticks", 32'(tick_cnt - t0), 32'd10);

        // Rollover.
        load(23, 59, 58);
        d0 = day_cnt;
        pulse(4, 4);
        check("roll_first", {21'd0, hour, min, sec}, {21'd0, 5'd23, 6'd59, 6'd59});
        check("roll_no_day", 32'(day_cnt - d0), 32'd0);
        pulse(4, 4);
        check("roll_second", {21'd0, hour, min, sec}, 32'd0);
        check("roll_day_once", 32'(day_cnt - d0), 32'd1);

        // Illegal load leaves time alone.
        e0 = err_cnt;
        load(12, 60, 0);
        check("bad_err", 32'(set_err), 32'd1);
        check("bad_ready_low", 32'(set_ready), 32'd0);
        check("bad_time", {21'd0, hour, min, sec}, 32'd0);
        step();
        check("bad_ready_back", 32'(set_ready), 32'd1);
        check("bad_err_once", 32'(err_cnt - e0), 32'd1);

        // Load collides with a detected second: load wins, second dropped.
        repeat (2) step();
        clk_1Hz = 1'b1;
        repeat (2) step();
        set_hour  = 5'd5;
        set_min   = 6'd6;
        set_sec   = 6'd7;
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        check("coll_time", {21'd0, hour, min, sec}, {21'd0, 5'd5, 6'd6, 6'd7});
        check("coll_tick", 32'(sec_tick), 32'd0);
        repeat (2) step();
        clk_1Hz = 1'b0;
        repeat (4) step();
        pulse(4, 4);
        check("coll_next", {21'd0, hour, min, sec}, {21'd0, 5'd5, 6'd6, 6'd8});

`ifdef TOD_PAUSE_EN
        t0 = tick_cnt;
        s0 = int'(sec);
        pause = 1'b1;
        repeat (3) pulse(4, 4);
        pause = 1'b0;
        check("pause_ticks", 32'(tick_cnt - t0), 32'd0);
        check("pause_frozen", 32'(sec), 32'(s0));
        pulse(4, 4);
        check("pause_resume", 32'(sec), 32'(s0 + 1));
`endif

        // Asynchronous reset with a load in flight.
        set_hour  = 5'd9;
        set_min   = 6'd9;
        set_sec   = 6'd9;
        set_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1 check("async_clear", {21'd0, hour, min, sec}, 32'd0);
        step();
        set_valid = 1'b0;
        reset_n   = 1'b1;
        repeat (2) step();

        // Randomized traffic, biased toward boundary fields.
        for (int i = 0; i < 3000; i++) begin
            if (!set_valid && $urandom_range(0, 19) == 0) begin
                set_hour  = ($urandom_range(0, 2) == 0) ? 5'd23 : 5'($urandom_range(0, 25));
                set_min   = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 63));
                set_sec   = ($urandom_range(0, 2) == 0) ? 6'd58 : 6'($urandom_range(0, 63));
                set_valid = 1'b1;
            end
            acc = set_valid && set_ready;
            if ($urandom_range(0, 4) == 0) clk_1Hz = ~clk_1Hz;
            step();
            if (acc) set_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
